mem_io_unit: RTL and testbench
==============================

Name: mem_io_unit

Overview:
- Memory/IO access stage between the SLC-3 control FSM and datapath on one side, and on-chip synchronous memory on the other.
- Takes MAR/MDR from the datapath and runs a fixed-latency read or write handshake.
- Returns read data on MDR_In, which the datapath's MIO mux loads into MDR. Signals completion with a one-cycle ready pulse R.
- Intercepts the memory-mapped IO address: reads return the switches; writes update the hex display register.

Parameters:
- WAIT_CYCLES, 2: cycles Mem_CE is held per memory access; must be >=1.
- IO_ADDR, 16'hFFFF: memory-mapped IO address (read = switches, write = hex display).

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  reset, asynchronous, active-low.
- Req  in  1  access request from control FSM; sampled only in IDLE.
- WE  in  1  1 = write, 0 = read; sampled with Req.
- MAR  in  16  access address from datapath.
- MDR  in  16  write data from datapath.
- MDR_In  out  16  read data to datapath MDR mux.
- R  out  1  ready; one-cycle pulse when the access completes.
- Mem_Addr  out  16  memory address.
- Mem_Din  out  16  memory write data.
- Mem_Dout  in  16  memory read data; valid in the last ACCESS cycle.
- Mem_CE  out  1  memory chip enable.
- Mem_WE  out  1  memory write enable; only asserted together with Mem_CE.
- Switches  in  16  board switches, read at IO_ADDR.
- Hex_Data  out  16  hex display register, written at IO_ADDR.

Behaviour:
- Reset (asynchronous, Reset_n=0):
  - state=IDLE, wait counter=0.
  - MDR_In, Hex_Data, Mem_Addr and Mem_Din all 16'h0000.
  - Mem_CE, Mem_WE and R all 0.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - Req=1 at edge t latches MAR into Mem_Addr, MDR into Mem_Din, and WE into an internal register.
  - If MAR != IO_ADDR: go to ACCESS, counter=0.
  - If MAR == IO_ADDR: go to DONE directly. A read captures Switches into MDR_In at edge t; a write loads MDR into Hex_Data at edge t. Mem_CE stays 0 throughout.
- ACCESS:
  - Mem_CE=1 and Mem_WE=latched WE for exactly WAIT_CYCLES cycles (t+1 .. t+WAIT_CYCLES).
  - Counter increments each cycle.
  - On the last cycle (counter==WAIT_CYCLES-1): a read captures Mem_Dout into MDR_In; the FSM then moves to DONE.
- DONE:
  - R=1 for exactly one cycle, Mem_CE=0, then unconditional return to IDLE.
  - Memory access: Req at edge t gives R high during cycle t+WAIT_CYCLES+1. IO access: R high during cycle t+1.
- MDR_In:
  - Holds its value until the next read completes.
  - A write never changes MDR_In.
- Hex_Data changes only on an IO write.
- Req in ACCESS or DONE is ignored, not queued. The control FSM must hold Req until it sees R, or re-issue it.
- MAR and MDR changes after the Req edge have no effect on the in-flight access.
- Address wrap: none. The address is passed through unchanged; only the exact match on IO_ADDR diverts.
- Reset mid-access: aborts immediately. Mem_CE and Mem_WE drop asynchronously, no R pulse, and MDR_In and Hex_Data are cleared.
- All outputs are registered; no combinational path from Req to the Mem_* outputs.

Decomposition:
- Shared package SLC3_2 gains:
  - mem_state_t enum {IDLE, ACCESS, DONE};
  - constant IO_ADDR_DEFAULT = 16'hFFFF.
- Counter width: $clog2(WAIT_CYCLES+1), computed locally.
- One sub-module, hex_io_reg: a 16-bit register with asynchronous active-low clear and load enable, driving Hex_Data. Instantiated once.

Test Plan:
- Reset: hold Reset_n=0 with Req=1 -> all outputs 0 and no Mem_CE; release, idle for 5 cycles -> R stays 0.
- Memory read, WAIT_CYCLES=2: MAR=x0010, WE=0, Req pulse at t, memory returns x1234 -> Mem_CE=1 at t+1..t+2, Mem_WE=0, R=1 only at t+3, MDR_In=x1234 from then on.
- Memory write: MAR=x0020, MDR=xBEEF, WE=1 -> Mem_Addr=x0020, Mem_Din=xBEEF, Mem_CE=Mem_WE=1 for 2 cycles, R at t+3, MDR_In unchanged.
- IO: Switches=x00AB, read at xFFFF -> R at t+1, MDR_In=x00AB, Mem_CE never asserted. Then write xCAFE to xFFFF -> Hex_Data=xCAFE, MDR_In stays x00AB.
- Busy: second Req with MAR=x0030 during ACCESS, plus MAR changed mid-access -> exactly one R, Mem_Addr stays x0010 throughout.
- Reset mid-access: Reset_n=0 in the first ACCESS cycle -> Mem_CE=0 immediately, no R pulse, MDR_In=0. A new read afterwards completes normally with 2-cycle latency.

Source files
------------

// File: rtl/mem_io_unit_pkg.sv
// rtl/mem_io_unit_pkg.sv - shared types and constants for the memory/IO access stage
package mem_io_unit_pkg;

    // Access sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

    // Default memory-mapped IO address: reads return switches, writes load the hex display
    localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;

endpackage

// File: rtl/mem_io_unit_if.sv
// rtl/mem_io_unit_if.sv - synchronous on-chip memory bus
interface mem_io_unit_if;

    logic [15:0] Mem_Addr;
    logic [15:0] Mem_Din;
    logic [15:0] Mem_Dout;
    logic        Mem_CE;
    logic        Mem_WE;

    // Access stage drives address, data and strobes; memory returns read data
    modport master (
        output Mem_Addr,
        output Mem_Din,
        output Mem_CE,
        output Mem_WE,
        input  Mem_Dout
    );

    modport slave (
        input  Mem_Addr,
        input  Mem_Din,
        input  Mem_CE,
        input  Mem_WE,
        output Mem_Dout
    );

endinterface

// File: rtl/mem_io_unit_hex_io_reg.sv
// rtl/mem_io_unit_hex_io_reg.sv - 16-bit hex display register with load enable
module hex_io_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld,
    input  logic [15:0] d,
    output logic [15:0] q
);

    logic [15:0] data_q;
    logic [15:0] data_d;

    // Hold value unless a load is requested
    always_comb begin
        data_d = data_q;
        if (ld) begin
            data_d = d;
        end
    end

    // Display register, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= 16'h0000;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/mem_io_unit.sv
// rtl/mem_io_unit.sv - fixed-latency memory/IO access stage for the SLC-3 datapath
module mem_io_unit
    import mem_io_unit_pkg::*;
#(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [15:0] IO_ADDR     = IO_ADDR_DEFAULT
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               Req,
    input  logic               WE,
    input  logic [15:0]        MAR,
    input  logic [15:0]        MDR,
    output logic [15:0]        MDR_In,
    output logic               R,
    input  logic [15:0]        Switches,
    output logic [15:0]        Hex_Data,
    mem_io_unit_if.master      mem
);

    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    mem_state_t       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [15:0]      addr_q,   addr_d;
    logic [15:0]      din_q,    din_d;
    logic             we_q,     we_d;
    logic             ce_q,     ce_d;
    logic             mwe_q,    mwe_d;
    logic             r_q,      r_d;
    logic [15:0]      mdr_in_q, mdr_in_d;
    logic             hex_ld;

    // Next-state and output computation; every output is taken from a flop
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        din_d    = din_q;
        we_d     = we_q;
        ce_d     = ce_q;
        mwe_d    = mwe_q;
        r_d      = 1'b0;
        mdr_in_d = mdr_in_q;
        hex_ld   = 1'b0;
        case (state_q)
            IDLE: begin
                if (Req) begin
                    addr_d = MAR;
                    din_d  = MDR;
                    we_d   = WE;
                    if (MAR == IO_ADDR) begin
                        // IO accesses complete without touching memory
                        state_d = DONE;
                        r_d     = 1'b1;
                        if (WE) begin
                            hex_ld = 1'b1;
                        end else begin
                            mdr_in_d = Switches;
                        end
                    end else begin
                        state_d = ACCESS;
                        cnt_d   = '0;
                        ce_d    = 1'b1;
                        mwe_d   = WE;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == CNT_LAST) begin
                    // Memory data is valid in the final enabled cycle
                    state_d = DONE;
                    cnt_d   = '0;
                    ce_d    = 1'b0;
                    mwe_d   = 1'b0;
                    r_d     = 1'b1;
                    if (!we_q) begin
                        mdr_in_d = mem.Mem_Dout;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                ce_d    = 1'b0;
                mwe_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any access in flight
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= 16'h0000;
            din_q    <= 16'h0000;
            we_q     <= 1'b0;
            ce_q     <= 1'b0;
            mwe_q    <= 1'b0;
            r_q      <= 1'b0;
            mdr_in_q <= 16'h0000;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            we_q     <= we_d;
            ce_q     <= ce_d;
            mwe_q    <= mwe_d;
            r_q      <= r_d;
            mdr_in_q <= mdr_in_d;
        end
    end

    hex_io_reg u_hex_io_reg (
        .clk   (Clk),
        .rst_n (Reset_n),
        .ld    (hex_ld),
        .d     (MDR),
        .q     (Hex_Data)
    );

    assign mem.Mem_Addr = addr_q;
    assign mem.Mem_Din  = din_q;
    assign mem.Mem_CE   = ce_q;
    assign mem.Mem_WE   = mwe_q;
    assign MDR_In       = mdr_in_q;
    assign R            = r_q;

endmodule

// File: tb/tb_mem_io_unit.sv
// tb/tb_mem_io_unit.sv - directed self-checking bench for mem_io_unit
module tb_mem_io_unit;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [15:0] mar;
    logic [15:0] mdr;
    logic [15:0] mdr_in;
    logic        r;
    logic [15:0] switches;
    logic [15:0] hex_data;

    int vectors;
    int miscompares;

    mem_io_unit_if bus ();

    mem_io_unit #(
        .WAIT_CYCLES (2),
        .IO_ADDR     (16'hFFFF)
    ) dut (
        .Clk      (clk),
        .Reset_n  (rst_n),
        .Req      (req),
        .WE       (we),
        .MAR      (mar),
        .MDR      (mdr),
        .MDR_In   (mdr_in),
        .R        (r),
        .Switches (switches),
        .Hex_Data (hex_data),
        .mem      (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic ce, input logic mwe, input logic rr);
        chk({tag, "_ce"}, {15'd0, bus.Mem_CE}, {15'd0, ce});
        chk({tag, "_we"}, {15'd0, bus.Mem_WE}, {15'd0, mwe});
        chk({tag, "_r"},  {15'd0, r},          {15'd0, rr});
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst_n        = 1'b0;
        req          = 1'b1;
        we           = 1'b0;
        mar          = 16'h0010;
        mdr          = 16'h1111;
        switches     = 16'h0000;
        bus.Mem_Dout = 16'h0000;

        // Reset held with Req asserted: nothing moves
        #1;
        chk_bus("rst0", 1'b0, 1'b0, 1'b0);
        step();
        step();
        chk_bus("rst1", 1'b0, 1'b0, 1'b0);
        chk("rst_mdr_in", mdr_in, 16'h0000);
        chk("rst_hex", hex_data, 16'h0000);
        chk("rst_addr", bus.Mem_Addr, 16'h0000);
        chk("rst_din", bus.Mem_Din, 16'h0000);
        req   = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_bus("idle", 1'b0, 1'b0, 1'b0);
        end

        // Memory read at 0x0010 returning 0x1234
        mar = 16'h0010; we = 1'b0; req = 1'b1; bus.Mem_Dout = 16'h1234;
        step(); req = 1'b0;
        chk_bus("rd_t1", 1'b1, 1'b0, 1'b0);
        chk("rd_addr", bus.Mem_Addr, 16'h0010);
        step();
        chk_bus("rd_t2", 1'b1, 1'b0, 1'b0);
        step();
        chk_bus("rd_t3", 1'b0, 1'b0, 1'b1);
        chk("rd_data", mdr_in, 16'h1234);
        step();
        chk_bus("rd_t4", 1'b0, 1'b0, 1'b0);
        chk("rd_hold", mdr_in, 16'h1234);

        // Memory write 0xBEEF to 0x0020
        mar = 16'h0020; mdr = 16'hBEEF; we = 1'b1; req = 1'b1; bus.Mem_Dout = 16'h7777;
        step(); req = 1'b0; mdr = 16'h0000;
        chk_bus("wr_t1", 1'b1, 1'b1, 1'b0);
        chk("wr_addr", bus.Mem_Addr, 16'h0020);
        chk("wr_din", bus.Mem_Din, 16'hBEEF);
        step();
        chk_bus("wr_t2", 1'b1, 1'b1, 1'b0);
        step();
        chk_bus("wr_t3", 1'b0, 1'b0, 1'b1);
        chk("wr_mdr_in", mdr_in, 16'h1234);
        chk("wr_hex", hex_data, 16'h0000);
        step();
        chk_bus("wr_t4", 1'b0, 1'b0, 1'b0);

        // IO read of switches
        switches = 16'h00AB; mar = 16'hFFFF; we = 1'b0; req = 1'b1;
        step(); req = 1'b0;
        chk_bus("ior_t1", 1'b0, 1'b0, 1'b1);
        chk("ior_data", mdr_in, 16'h00AB);
        step();
        chk_bus("ior_t2", 1'b0, 1'b0, 1'b0);

        // IO write to hex display
        mdr = 16'hCAFE; we = 1'b1; req = 1'b1;
        step(); req = 1'b0;
        chk_bus("iow_t1", 1'b0, 1'b0, 1'b1);
        chk("iow_hex", hex_data, 16'hCAFE);
        chk("iow_mdr_in", mdr_in, 16'h00AB);
        step();
        chk_bus("iow_t2", 1'b0, 1'b0, 1'b0);
        chk("iow_hold", hex_data, 16'hCAFE);

        // Address one below IO goes to memory
        mar = 16'hFFFE; we = 1'b0; req = 1'b1; bus.Mem_Dout = 16'h0F0F;
        step(); req = 1'b0;
        chk_bus("fffe_t1", 1'b1, 1'b0, 1'b0);
        step();
        step();
        chk_bus("fffe_t3", 1'b0, 1'b0, 1'b1);
        chk("fffe_data", mdr_in, 16'h0F0F);
        chk("fffe_hex", hex_data, 16'hCAFE);
        step();

        // Busy: Req held and MAR changed mid-access
        mar = 16'h0010; we = 1'b0; req = 1'b1; bus.Mem_Dout = 16'h5678;
        step(); mar = 16'h0030;
        chk_bus("busy_t1", 1'b1, 1'b0, 1'b0);
        step(); req = 1'b0;
        chk_bus("busy_t2", 1'b1, 1'b0, 1'b0);
        chk("busy_addr2", bus.Mem_Addr, 16'h0010);
        step();
        chk_bus("busy_t3", 1'b0, 1'b0, 1'b1);
        chk("busy_data", mdr_in, 16'h5678);
        chk("busy_addr3", bus.Mem_Addr, 16'h0010);
        step();
        chk_bus("busy_t4", 1'b0, 1'b0, 1'b0);
        step();
        chk_bus("busy_t5", 1'b0, 1'b0, 1'b0);

        // Reset in the first ACCESS cycle
        mar = 16'h0040; we = 1'b1; mdr = 16'h2222; req = 1'b1; bus.Mem_Dout = 16'h9999;
        step(); req = 1'b0;
        chk_bus("mrst_t1", 1'b1, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_bus("mrst_now", 1'b0, 1'b0, 1'b0);
        chk("mrst_mdr_in", mdr_in, 16'h0000);
        chk("mrst_hex", hex_data, 16'h0000);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_bus("mrst_idle", 1'b0, 1'b0, 1'b0);
        end

        // Fresh read after reset completes normally
        mar = 16'h0050; we = 1'b0; req = 1'b1; bus.Mem_Dout = 16'h4321;
        step(); req = 1'b0;
        chk_bus("post_t1", 1'b1, 1'b0, 1'b0);
        chk("post_addr", bus.Mem_Addr, 16'h0050);
        step();
        chk_bus("post_t2", 1'b1, 1'b0, 1'b0);
        step();
        chk_bus("post_t3", 1'b0, 1'b0, 1'b1);
        chk("post_data", mdr_in, 16'h4321);
        step();
        chk_bus("post_t4", 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
